// File: rtl/rd_dbi_decoder.sv
// Read-path DBI decoder with a two-entry output buffer.
// Lanes flagged inverted are restored; inverted lanes are counted.
module rd_dbi_decoder #(
    parameter int DATA_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dbi_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_dbi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        inv_count
);

    localparam int W  = 8 * DATA_BYTES;
    localparam int PW = $clog2(DATA_BYTES + 1);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_n;
    logic         rdy_q;
    logic         vld_q;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;
    logic [W-1:0] dec;
    logic [PW-1:0] inv_lanes;
    logic [CNT_W:0] cnt_sum;
    logic [CNT_W-1:0] cnt_q;
    logic         acc;
    logic         con;
    logic         ld_out;
    logic         ld_skid;
    logic         mv_skid;

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = out_q;
    assign inv_count = cnt_q;

    assign acc = in_valid & rdy_q;
    assign con = vld_q & out_ready;

    // Restore inverted lanes and count how many were inverted
    always_comb begin
        dec       = in_data;
        inv_lanes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (dbi_en && in_dbi[i]) begin
                dec[8*i +: 8] = ~in_data[8*i +: 8];
                inv_lanes     = inv_lanes + PW'(1);
            end
        end
    end

    assign cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(inv_lanes);

    // Buffer occupancy transitions and data-register load selects
    always_comb begin
        state_n = state;
        ld_out  = 1'b0;
        ld_skid = 1'b0;
        mv_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_n = ONE;
                    ld_out  = 1'b1;
                end
            end
            ONE: begin
                if (acc && !con) begin
                    state_n = TWO;
                    ld_skid = 1'b1;
                end else if (!acc && con) begin
                    state_n = EMPTY;
                end else if (acc && con) begin
                    ld_out = 1'b1;
                end
            end
            TWO: begin
                if (con) begin
                    state_n = ONE;
                    mv_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // State plus registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n != TWO);
            vld_q <= (state_n != EMPTY);
        end
    end

    // Output and skid data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (ld_out) begin
                out_q <= dec;
            end else if (mv_skid) begin
                out_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= dec;
            end
        end
    end

    // Saturating inverted-lane counter, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_rd_dbi_decoder.sv
// Bench for rd_dbi_decoder: directed checks plus random traffic
// against a queue-based reference model.
module tb_rd_dbi_decoder;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbi_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_dbi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        cnt_clr;
    logic [CW-1:0] inv_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_m    = 0;
    int beats_out = 0;
    logic [31:0] q[$];

    rd_dbi_decoder #(.DATA_BYTES(4), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .dbi_en(dbi_en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_dbi(in_dbi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .cnt_clr(cnt_clr),
        .inv_count(inv_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_dec(input logic [31:0] d,
                                              input logic [3:0] f,
                                              input logic en);
        logic [31:0] r;
        int b;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            b = int'((d >> (8 * i)) & 32'hFF);
            if (en && f[i]) b = 255 - b;
            r = r + (32'(b) << (8 * i));
        end
        return r;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc;
        bit con;
        int add;
        logic [31:0] d;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) check("out_data", out_data, q[0]);
        acc = in_valid && (q.size() < 2);
        con = out_ready && (q.size() > 0);
        d = model_dec(in_data, in_dbi, dbi_en);
        add = dbi_en ? $countones(in_dbi) : 0;
        @(posedge clk);
        #1;
        if (con) begin
            void'(q.pop_front());
            beats_out++;
        end
        if (acc) q.push_back(d);
        if (cnt_clr) cnt_m = 0;
        else if (acc) cnt_m = (cnt_m + add > CMAX) ? CMAX : cnt_m + add;
        check("inv_count", 32'(inv_count), 32'(cnt_m));
    endtask

    initial begin
        rst = 1'b1;
        dbi_en = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_dbi = '0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_data", out_data, 0);
        check("rst_inv_count", 32'(inv_count), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // decode check
        dbi_en = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h00FF_A55A;
        in_dbi = 4'b0101;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("dec_data", out_data, 32'h0000_A5A5);
        check("dec_cnt", 32'(inv_count), 2);
        tick();

        // backpressure check
        dbi_en = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1111_1111;
        tick();
        in_data = 32'h2222_2222;
        tick();
        in_data = 32'h3333_3333;
        check("bp_in_ready", 32'(in_ready), 0);
        tick();
        check("bp_hold", out_data, 32'h1111_1111);
        out_ready = 1'b1;
        tick();
        check("bp_b2", out_data, 32'h2222_2222);
        tick();
        in_valid = 1'b0;
        check("bp_b3", out_data, 32'h3333_3333);
        tick();
        tick();

        // enable check
        dbi_en = 1'b0;
        in_valid = 1'b1;
        in_dbi = 4'b1111;
        in_data = 32'h1234_5678;
        tick();
        in_valid = 1'b0;
        check("en_data", out_data, 32'h1234_5678);
        check("en_cnt", 32'(inv_count), 2);
        tick();

        // counter saturation and clear
        dbi_en = 1'b1;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        in_valid = 1'b1;
        in_dbi = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            tick();
        end
        check("cnt_sat", 32'(inv_count), 15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        check("cnt_clr_acc", 32'(inv_count), 0);
        tick();

        // throughput check
        beats_out = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = $urandom;
            in_dbi = 4'($urandom);
            dbi_en = 1'($urandom);
            tick();
            check("tp_in_ready", 32'(in_ready), 1);
            check("tp_one", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        tick();
        check("tp_beats", 32'(beats_out), 100);

        // reset from the full state
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        tick();
        in_data = 32'hCAFE_F00D;
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_cnt", 32'(inv_count), 0);
        q.delete();
        cnt_m = 0;
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_empty", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data = 32'h0BAD_CAFE;
        in_dbi = 4'b0000;
        tick();
        in_valid = 1'b0;
        check("post_rst_first", out_data, 32'h0BAD_CAFE);
        tick();
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            dbi_en = 1'($urandom);
            in_dbi = 4'($urandom);
            in_data = $urandom;
            cnt_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        tick();
        tick();
        tick();
        check("drain_empty", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
